// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece IDs and bag constants.
package tetris_pkg;

  typedef enum logic [2:0] {
    I = 3'd0,
    O = 3'd1,
    T = 3'd2,
    S = 3'd3,
    Z = 3'd4,
    J = 3'd5,
    L = 3'd6
  } piece_e;

  localparam int num_pieces_gp = 7;
  localparam logic [num_pieces_gp-1:0] bag_full_gp = 7'h7F;

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR with synchronous load.
module lfsr_galois #(
  parameter int                 width_p = 16,
  parameter logic [width_p-1:0] mask_p  = 16'hB400,
  parameter logic [width_p-1:0] seed_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_data_i,
  output logic [width_p-1:0] o
);

  // Advance every cycle; a load overrides the step.
  always_ff @(posedge clk_i) begin
    if (reset_i)     o <= seed_p;
    else if (load_i) o <= load_data_i;
    else             o <= (o >> 1) ^ (o[0] ? mask_p : '0);
  end

endmodule

// File: rtl/tetromino_bag_generator.sv
// Tetromino source: LFSR-driven rejection sampler, optional 7-bag fairness
// mask and a two-entry head/preview queue with a valid/yumi handshake.
module tetromino_bag_generator
  import tetris_pkg::*;
#(
  parameter int                 width_p = 16,
  parameter logic [width_p-1:0] mask_p  = 16'hB400,
  parameter logic [width_p-1:0] seed_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               seed_v_i,
  input  logic [width_p-1:0] seed_i,
  input  logic               bag_en_i,
  output logic [2:0]         piece_o,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [2:0]         next_o,
  output logic               next_v_o,
  output logic [width_p-1:0] lfsr_o
);

  logic [width_p-1:0]       lfsr;
  logic [width_p-1:0]       load_data;
  logic [2:0]               cand;
  logic [num_pieces_gp-1:0] used, used_eff, used_set, used_next;
  logic                     bag_q;
  logic                     yumi_eff, full, acc;

  // A zero seed would lock the LFSR, so it is promoted to 1.
  assign load_data = (seed_i == '0) ? width_p'(1) : seed_i;

  lfsr_galois #(
    .width_p(width_p),
    .mask_p (mask_p),
    .seed_p (seed_p)
  ) u_lfsr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (seed_v_i),
    .load_data_i(load_data),
    .o          (lfsr)
  );

  assign lfsr_o = lfsr;
  assign cand   = lfsr[2:0];

  // Sampler: yumi is masked when nothing is valid or a reseed flushes the queue.
  always_comb begin
    yumi_eff  = yumi_i & v_o & ~seed_v_i;
    full      = v_o & next_v_o;
    used_eff  = (bag_en_i != bag_q) ? '0 : used;
    acc       = (cand != 3'(num_pieces_gp)) && (!full || yumi_eff) && !seed_v_i
                && (!bag_en_i || !used_eff[cand]);
    used_set  = used_eff | ((acc && bag_en_i) ? (7'b1 << cand) : 7'b0);
    used_next = used_set;
    if (!bag_en_i || seed_v_i || used_set == bag_full_gp) used_next = '0;
  end

  // Bag mask and the mode it was built under.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      used  <= '0;
      bag_q <= 1'b0;
    end else begin
      used  <= used_next;
      bag_q <= bag_en_i;
    end
  end

  // Two-entry queue: head feeds piece_o, tail feeds the preview.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_o      <= 1'b0;
      next_v_o <= 1'b0;
      piece_o  <= I;
      next_o   <= I;
    end else if (seed_v_i) begin
      v_o      <= 1'b0;
      next_v_o <= 1'b0;
    end else if (yumi_eff && acc) begin
      if (next_v_o) begin
        piece_o <= next_o;
        next_o  <= cand;
      end else begin
        piece_o <= cand;
      end
    end else if (yumi_eff) begin
      piece_o  <= next_o;
      v_o      <= next_v_o;
      next_v_o <= 1'b0;
    end else if (acc) begin
      if (!v_o) begin
        piece_o <= cand;
        v_o     <= 1'b1;
      end else begin
        next_o   <= cand;
        next_v_o <= 1'b1;
      end
    end
  end

  illegal_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
                                 !(yumi_i && !v_o));

endmodule

// File: tb/tb_tetromino_bag_generator.sv
// Self-checking bench: scenario tasks against a queue/array reference model.
module tb_tetromino_bag_generator;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       seed_v_i = 1'b0;
  logic [3:0] seed_i = 4'd0;
  logic       bag_en_i = 1'b0;
  logic       yumi_i = 1'b0;
  logic [2:0] piece_o, next_o;
  logic       v_o, next_v_o;
  logic [3:0] lfsr_o;

  int checks = 0;
  int errors = 0;

  tetromino_bag_generator #(
    .width_p(4),
    .mask_p (4'b1100),
    .seed_p (4'b0001)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .seed_v_i(seed_v_i),
    .seed_i  (seed_i),
    .bag_en_i(bag_en_i),
    .piece_o (piece_o),
    .v_o     (v_o),
    .yumi_i  (yumi_i),
    .next_o  (next_o),
    .next_v_o(next_v_o),
    .lfsr_o  (lfsr_o)
  );

  always #5 clk = ~clk;

  // Reference model: LFSR as a number, queue of IDs, set of drawn pieces.
  int unsigned m_lfsr;
  int          mq[$];
  bit          m_used[7];
  bit          m_prev_bag;

  task automatic model_reset();
    m_lfsr = 1;
    mq.delete();
    foreach (m_used[k]) m_used[k] = 0;
    m_prev_bag = 0;
  endtask

  task automatic model_step(input bit sv, input int unsigned sd, input bit bag, input bit y);
    int  c;
    bit  take, acc, all;
    c = m_lfsr % 8;
    if (sv) begin
      m_lfsr = (sd == 0) ? 1 : sd;
      mq.delete();
      foreach (m_used[k]) m_used[k] = 0;
      m_prev_bag = bag;
      return;
    end
    take = y && mq.size() > 0;
    if (bag != m_prev_bag) foreach (m_used[k]) m_used[k] = 0;
    m_prev_bag = bag;
    acc = (c != 7) && (mq.size() < 2 || take) && (!bag || !m_used[c]);
    if (take) void'(mq.pop_front());
    if (acc) mq.push_back(c);
    if (acc && bag) begin
      m_used[c] = 1;
      all = 1;
      foreach (m_used[k]) if (!m_used[k]) all = 0;
      if (all) foreach (m_used[k]) m_used[k] = 0;
    end
    if (!bag) foreach (m_used[k]) m_used[k] = 0;
    m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 12 : 0);
  endtask

  // Inputs change at the negedge, the DUT steps on the posedge.
  task automatic tick(input bit sv, input logic [3:0] sd, input bit bag, input bit y);
    seed_v_i = sv; seed_i = sd; bag_en_i = bag; yumi_i = y;
    model_step(sv, sd, bag, y);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1; seed_v_i = 0; yumi_i = 0;
    @(negedge clk);
    reset_i = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (v_o !== 1'b0)      begin errors++; $display("FAIL reset_v got=%0b exp=0", v_o); end
    checks++; if (next_v_o !== 1'b0) begin errors++; $display("FAIL reset_next_v got=%0b exp=0", next_v_o); end
    checks++; if (piece_o !== 3'd0)  begin errors++; $display("FAIL reset_piece got=%0d exp=0", piece_o); end
    checks++; if (next_o !== 3'd0)   begin errors++; $display("FAIL reset_next got=%0d exp=0", next_o); end
    checks++; if (lfsr_o !== 4'd1)   begin errors++; $display("FAIL reset_lfsr got=%0d exp=1", lfsr_o); end
  endtask

  task automatic test_lfsr_seq();
    int exp[8] = '{1, 12, 6, 3, 13, 10, 5, 14};
    do_reset();
    for (int i = 0; i <= 15; i++) begin
      if (i < 8) begin
        checks++;
        if (lfsr_o !== 4'(exp[i])) begin errors++; $display("FAIL lfsr_seq[%0d] got=%0d exp=%0d", i, lfsr_o, exp[i]); end
      end else if (i < 15) begin
        checks++;
        if (lfsr_o === 4'd1) begin errors++; $display("FAIL lfsr_period[%0d] got=1 early", i); end
      end else begin
        checks++;
        if (lfsr_o !== 4'd1) begin errors++; $display("FAIL lfsr_wrap got=%0d exp=1", lfsr_o); end
      end
      tick(0, 0, 0, 0);
    end
  endtask

  task automatic run_drain(input bit bag, input int cycles, output int got[$]);
    bit y;
    got.delete();
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      checks++;
      if (v_o !== (mq.size() > 0)) begin errors++; $display("FAIL drain_v cyc=%0d got=%0b exp=%0b", i, v_o, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++;
        if (piece_o !== 3'(mq[0])) begin errors++; $display("FAIL drain_piece cyc=%0d got=%0d exp=%0d", i, piece_o, mq[0]); end
      end
      y = mq.size() > 0;
      if (y) got.push_back(int'(piece_o));
      tick(0, 0, bag, y);
    end
  endtask

  task automatic test_uniform();
    int got[$];
    int exp[8] = '{1, 4, 6, 3, 5, 2, 5, 6};
    run_drain(0, 20, got);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got.size() <= i || got[i] != exp[i]) begin
        errors++; $display("FAIL uniform_seq[%0d] got=%0d exp=%0d", i, (got.size() > i) ? got[i] : -1, exp[i]);
      end
    end
  endtask

  task automatic test_bag();
    int got[$];
    int exp[10] = '{1, 4, 6, 3, 5, 2, 0, 4, 2, 1};
    run_drain(1, 30, got);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got.size() <= i || got[i] != exp[i]) begin
        errors++; $display("FAIL bag_seq[%0d] got=%0d exp=%0d", i, (got.size() > i) ? got[i] : -1, exp[i]);
      end
    end
  endtask

  task automatic test_full_queue();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i >= 1 && i <= 5) begin
        checks++;
        if (v_o !== 1'b1 || piece_o !== 3'd1) begin errors++; $display("FAIL full_head cyc=%0d got=%0d/%0b exp=1/1", i, piece_o, v_o); end
      end
      if (i >= 2 && i <= 5) begin
        checks++;
        if (next_v_o !== 1'b1 || next_o !== 3'd4) begin errors++; $display("FAIL full_next cyc=%0d got=%0d/%0b exp=4/1", i, next_o, next_v_o); end
      end
      if (i == 6) begin
        checks++;
        if (piece_o !== 3'd4 || v_o !== 1'b1) begin errors++; $display("FAIL full_pop_head got=%0d exp=4", piece_o); end
        checks++;
        if (next_o !== 3'd2 || next_v_o !== 1'b1) begin errors++; $display("FAIL full_refill got=%0d exp=2", next_o); end
      end
      tick(0, 0, 0, i == 5);
    end
  endtask

  task automatic test_reseed();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        checks++;
        if (v_o !== 1'b0 || next_v_o !== 1'b0) begin errors++; $display("FAIL reseed_flush got=%0b/%0b exp=0/0", v_o, next_v_o); end
        checks++;
        if (lfsr_o !== 4'd1) begin errors++; $display("FAIL reseed_lfsr got=%0d exp=1", lfsr_o); end
      end
      if (i == 9) begin
        checks++;
        if (v_o !== 1'b1 || piece_o !== 3'd1) begin errors++; $display("FAIL reseed_first got=%0d/%0b exp=1/1", piece_o, v_o); end
      end
      tick(i == 7, 4'd0, 0, mq.size() > 0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);
    reset_i = 1; yumi_i = 1;
    @(negedge clk);
    checks++;
    if (v_o !== 1'b0 || next_v_o !== 1'b0 || piece_o !== 3'd0 || next_o !== 3'd0 || lfsr_o !== 4'd1) begin
      errors++;
      $display("FAIL reset_mid got=v%0b n%0b p%0d x%0d l%0d exp=v0 n0 p0 x0 l1", v_o, next_v_o, piece_o, next_o, lfsr_o);
    end
    reset_i = 0; yumi_i = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit bag = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (lfsr_o !== 4'(m_lfsr)) begin errors++; $display("FAIL rnd_lfsr cyc=%0d got=%0d exp=%0d", i, lfsr_o, m_lfsr); end
      checks++;
      if (v_o !== (mq.size() > 0) || next_v_o !== (mq.size() > 1)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%0b%0b exp=%0b%0b", i, v_o, next_v_o, mq.size() > 0, mq.size() > 1);
      end
      if (mq.size() > 0) begin
        checks++;
        if (piece_o !== 3'(mq[0])) begin errors++; $display("FAIL rnd_piece cyc=%0d got=%0d exp=%0d", i, piece_o, mq[0]); end
      end
      if (mq.size() > 1) begin
        checks++;
        if (next_o !== 3'(mq[1])) begin errors++; $display("FAIL rnd_next cyc=%0d got=%0d exp=%0d", i, next_o, mq[1]); end
      end
      if ($urandom_range(0, 15) == 0) bag = ~bag;
      tick($urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)), bag,
           mq.size() > 0 && $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_seq();
    test_uniform();
    test_bag();
    test_full_queue();
    test_reseed();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
